// File: rtl/sram_ctrl.sv
// sram_ctrl: bridges cache line-fill reads (4 x 16-bit words -> 64-bit line)
// and 32-bit write-through writes (2 x 16-bit words) onto an asynchronous
// 16-bit SRAM. Every SRAM word is held for N = WAIT_CYC+1 cycles.
//
// Ports:
//   clk, rst          clock; asynchronous active-low reset
//   req_r, req_w      level requests (read wins when both are high)
//   req_adr           byte address, bits [18:1] used
//   req_wdata         write data
//   rsp_rdata         assembled 64-bit line (registered, updated on read completion)
//   rsp_ready         one-cycle completion pulse
//   sram_addr         SRAM word address (registered)
//   sram_dq_o/_oe     SRAM write data and bus drive enable
//   sram_dq_i         SRAM read data
//   sram_we_n         SRAM write strobe, active-low
module sram_ctrl #(
    parameter int WAIT_CYC = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_r,
    input  logic        req_w,
    input  logic [31:0] req_adr,
    input  logic [31:0] req_wdata,
    output logic [63:0] rsp_rdata,
    output logic        rsp_ready,
    output logic [17:0] sram_addr,
    output logic [15:0] sram_dq_o,
    output logic        sram_dq_oe,
    input  logic [15:0] sram_dq_i,
    output logic        sram_we_n
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    // last cycle of a phase, and the cycle before it (where we_n is raised
    // so it is high during the final cycle of each write phase)
    localparam logic [3:0] CYC_LAST = 4'(WAIT_CYC);
    localparam logic [3:0] WE_RISE  = 4'(WAIT_CYC - 1);

    state_t      state;
    logic [3:0]  cyc;
    logic [1:0]  wrd;
    logic [47:0] line_buf;   // words 0..2 of a fill; rsp_rdata only moves at completion
    logic [15:0] wdata_hi;   // captured upper half of the write data

    logic unused_adr;
    assign unused_adr = ^{req_adr[31:19], req_adr[0]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            cyc        <= '0;
            wrd        <= '0;
            line_buf   <= '0;
            wdata_hi   <= '0;
            rsp_rdata  <= '0;
            rsp_ready  <= 1'b0;
            sram_addr  <= '0;
            sram_dq_o  <= '0;
            sram_dq_oe <= 1'b0;
            sram_we_n  <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    rsp_ready <= 1'b0;
                    cyc       <= '0;
                    wrd       <= '0;
                    if (req_r) begin
                        state      <= READ;
                        sram_addr  <= {req_adr[18:3], 2'b00};
                        sram_dq_oe <= 1'b0;
                        sram_we_n  <= 1'b1;
                    end else if (req_w) begin
                        state      <= WRITE;
                        sram_addr  <= {req_adr[18:2], 1'b0};
                        sram_dq_o  <= req_wdata[15:0];
                        wdata_hi   <= req_wdata[31:16];
                        sram_dq_oe <= 1'b1;
                        sram_we_n  <= 1'b0;
                    end
                end

                READ: begin
                    if (cyc == CYC_LAST) begin
                        cyc <= '0;
                        wrd <= wrd + 2'd1;
                        case (wrd)
                            2'd0: line_buf[15:0]  <= sram_dq_i;
                            2'd1: line_buf[31:16] <= sram_dq_i;
                            2'd2: line_buf[47:32] <= sram_dq_i;
                            default: begin
                                rsp_rdata <= {sram_dq_i, line_buf};
                                rsp_ready <= 1'b1;
                                state     <= DONE;
                            end
                        endcase
                        if (wrd != 2'd3)
                            sram_addr[1:0] <= wrd + 2'd1;
                    end else begin
                        cyc <= cyc + 4'd1;
                    end
                end

                WRITE: begin
                    if (cyc == CYC_LAST) begin
                        cyc <= '0;
                        wrd <= wrd + 2'd1;
                        if (wrd[0]) begin
                            state      <= DONE;
                            rsp_ready  <= 1'b1;
                            sram_dq_oe <= 1'b0;
                            sram_we_n  <= 1'b1;
                        end else begin
                            sram_addr[0] <= 1'b1;
                            sram_dq_o    <= wdata_hi;
                            sram_we_n    <= 1'b0;
                        end
                    end else begin
                        cyc <= cyc + 4'd1;
                        if (cyc == WE_RISE)
                            sram_we_n <= 1'b1;
                    end
                end

                DONE: begin
                    rsp_ready <= 1'b0;
                    state     <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_ctrl.sv
// Self-checking bench for sram_ctrl: directed table, hand-written corner
// sequences (hold-through, early drop, mid-operation reset) and randomized
// operations against a word-array reference model.
module tb_sram_ctrl;
    localparam int WAIT_CYC = 2;
    localparam int N        = WAIT_CYC + 1;
    localparam int RD_LAT   = 4 * N + 1;
    localparam int WR_LAT   = 2 * N + 1;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_r = 1'b0, req_w = 1'b0;
    logic [31:0] req_adr = '0, req_wdata = '0;
    logic [63:0] rsp_rdata;
    logic        rsp_ready;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_o, sram_dq_i;
    logic        sram_dq_oe, sram_we_n;

    sram_ctrl #(.WAIT_CYC(WAIT_CYC)) dut (
        .clk(clk), .rst(rst), .req_r(req_r), .req_w(req_w),
        .req_adr(req_adr), .req_wdata(req_wdata),
        .rsp_rdata(rsp_rdata), .rsp_ready(rsp_ready),
        .sram_addr(sram_addr), .sram_dq_o(sram_dq_o), .sram_dq_oe(sram_dq_oe),
        .sram_dq_i(sram_dq_i), .sram_we_n(sram_we_n)
    );

    always #5 clk = ~clk;

    // SRAM model: async read, write latched on the rising edge of we_n
    logic [15:0] sram_mem [0:262143];
    logic [15:0] ref_mem  [0:262143];
    assign sram_dq_i = sram_mem[sram_addr];
    always @(posedge sram_we_n)
        if (sram_dq_oe === 1'b1) sram_mem[sram_addr] = sram_dq_o;

    int we_low;
    always @(negedge clk) if (sram_we_n === 1'b0) we_low++;

    int n_tests = 0, n_fail = 0;
    logic [63:0] exp_last;   // model's view of rsp_rdata

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] iv(input int a);
        return 16'(a) ^ 16'h5A5A;
    endfunction

    function automatic logic [63:0] ref_line(input logic [31:0] adr);
        int b;
        b = int'({adr[18:3], 2'b00});
        return {ref_mem[b+3], ref_mem[b+2], ref_mem[b+1], ref_mem[b]};
    endfunction

    task automatic ref_write(input logic [31:0] adr, input logic [31:0] wd);
        ref_mem[int'({adr[18:2], 1'b0})] = wd[15:0];
        ref_mem[int'({adr[18:2], 1'b1})] = wd[31:16];
    endtask

    // One operation: request at the negedge, accepted at the next posedge.
    // Inputs are scrambled after acceptance; drop_at>0 drops the request early.
    task automatic run_op(input logic rd, input logic wr, input logic [31:0] adr,
                          input logic [31:0] wd, input int drop_at, output int lat);
        @(negedge clk);
        req_r = rd; req_w = wr; req_adr = adr; req_wdata = wd; we_low = 0;
        @(posedge clk);
        lat = -1;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            if (k == 1) begin req_adr = $urandom; req_wdata = $urandom; end
            if (k == drop_at) begin req_r = 1'b0; req_w = 1'b0; end
            if (rsp_ready) begin lat = k; break; end
        end
        req_r = 1'b0; req_w = 1'b0;
        @(negedge clk);
        chk("ready_one_cycle", {63'd0, rsp_ready}, 64'd0);
    endtask

    typedef struct {
        logic        rd, wr;
        logic [31:0] adr, wd;
        logic [63:0] exp_rdata;
        int          exp_lat;
        int          exp_welow;
    } vec_t;

    vec_t vt[5];

    initial begin
        int lat, saw;
        logic [63:0] line;

        fork
            begin
                #2000000;
                $display("FAIL watchdog: got timeout expected finish");
                $fatal(1, "watchdog");
            end
        join_none

        for (int i = 0; i < 262144; i++) begin
            sram_mem[i] = iv(i);
            ref_mem[i]  = iv(i);
        end
        for (int i = 0; i < 4; i++) begin
            sram_mem[32'h94 + i] = 16'h1111 * 16'(i + 1);
            ref_mem[32'h94 + i]  = 16'h1111 * 16'(i + 1);
        end

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_ready", {63'd0, rsp_ready}, 64'd0);
        chk("rst_rdata", rsp_rdata, 64'd0);
        chk("rst_addr",  {46'd0, sram_addr}, 64'd0);
        chk("rst_dq_o",  {48'd0, sram_dq_o}, 64'd0);
        chk("rst_oe",    {63'd0, sram_dq_oe}, 64'd0);
        chk("rst_we_n",  {63'd0, sram_we_n}, 64'd1);
        rst = 1'b1;
        exp_last = '0;

        // directed table
        vt[0] = '{1'b1, 1'b0, 32'h0000_0128, 32'h0, 64'h4444_3333_2222_1111, RD_LAT, 0};
        vt[1] = '{1'b0, 1'b1, 32'h0000_0104, 32'hDEAD_BEEF, 64'h4444_3333_2222_1111, WR_LAT, 2*(N-1)};
        vt[2] = '{1'b1, 1'b1, 32'h0000_0104, 32'h1234_5678,
                  {16'hDEAD, 16'hBEEF, iv(32'h81), iv(32'h80)}, RD_LAT, 0};
        vt[3] = '{1'b1, 1'b0, 32'hFFF8_012F, 32'h0, 64'h4444_3333_2222_1111, RD_LAT, 0};
        vt[4] = '{1'b0, 1'b1, 32'h0000_0106, 32'hCAFE_F00D, 64'h4444_3333_2222_1111, WR_LAT, 2*(N-1)};
        for (int i = 0; i < 5; i++) begin
            run_op(vt[i].rd, vt[i].wr, vt[i].adr, vt[i].wd, 0, lat);
            chk($sformatf("vec%0d_lat", i), 64'(lat), 64'(vt[i].exp_lat));
            chk($sformatf("vec%0d_rdata", i), rsp_rdata, vt[i].exp_rdata);
            chk($sformatf("vec%0d_we_low", i), 64'(we_low), 64'(vt[i].exp_welow));
            if (!vt[i].rd) begin
                chk($sformatf("vec%0d_mem_lo", i),
                    {48'd0, sram_mem[int'({vt[i].adr[18:2], 1'b0})]}, {48'd0, vt[i].wd[15:0]});
                chk($sformatf("vec%0d_mem_hi", i),
                    {48'd0, sram_mem[int'({vt[i].adr[18:2], 1'b1})]}, {48'd0, vt[i].wd[31:16]});
                ref_write(vt[i].adr, vt[i].wd);
            end
        end
        exp_last = 64'h4444_3333_2222_1111;

        // early drop of req_r: all words still fetched
        run_op(1'b1, 1'b0, 32'h0000_0128, 32'h0, 2, lat);
        chk("drop_lat", 64'(lat), 64'(RD_LAT));
        chk("drop_rdata", rsp_rdata, 64'h4444_3333_2222_1111);

        // req_r held through DONE starts a second read from IDLE
        @(negedge clk);
        req_r = 1'b1; req_adr = 32'h0000_0100;
        @(posedge clk);
        saw = 0;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            if (rsp_ready) begin
                saw++;
                chk($sformatf("hold_lat%0d", saw), 64'(k), 64'(saw * (RD_LAT + 1) - 1));
                if (saw == 2) break;
            end
        end
        req_r = 1'b0;
        chk("hold_count", 64'(saw), 64'd2);
        chk("hold_rdata", rsp_rdata, ref_line(32'h0000_0100));
        exp_last = ref_line(32'h0000_0100);
        @(negedge clk);
        // second read's follow-up: IDLE, nothing pending
        chk("hold_idle", {63'd0, rsp_ready}, 64'd0);

        // reset mid-read: immediate reset values, no completion, then a normal write
        @(negedge clk);
        req_r = 1'b1; req_adr = 32'h0000_0128;
        @(posedge clk);
        repeat (4) @(negedge clk);
        @(negedge clk);
        req_r = 1'b0;
        rst = 1'b0;
        #1;
        chk("mid_rst_ready", {63'd0, rsp_ready}, 64'd0);
        chk("mid_rst_rdata", rsp_rdata, 64'd0);
        chk("mid_rst_addr",  {46'd0, sram_addr}, 64'd0);
        chk("mid_rst_dq_o",  {48'd0, sram_dq_o}, 64'd0);
        chk("mid_rst_oe",    {63'd0, sram_dq_oe}, 64'd0);
        chk("mid_rst_we_n",  {63'd0, sram_we_n}, 64'd1);
        @(negedge clk);
        rst = 1'b1;
        saw = 0;
        repeat (20) @(negedge clk) if (rsp_ready || !sram_we_n || sram_dq_oe) saw++;
        chk("post_rst_quiet", 64'(saw), 64'd0);
        exp_last = '0;
        run_op(1'b0, 1'b1, 32'h0000_0104, 32'hA5A5_0F0F, 0, lat);
        ref_write(32'h0000_0104, 32'hA5A5_0F0F);
        chk("post_rst_wr_lat", 64'(lat), 64'(WR_LAT));
        chk("post_rst_rdata", rsp_rdata, 64'd0);

        // randomized operations against the reference model
        for (int t = 0; t < 60; t++) begin
            logic [31:0] adr, wd;
            int kind, drop;
            adr  = ($urandom & 32'hFFF8_0001) | (32'($urandom_range(128, 191)) << 1);
            wd   = $urandom;
            kind = $urandom_range(0, 2);
            drop = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 5) : 0;
            repeat ($urandom_range(0, 3)) @(negedge clk);
            run_op(kind != 1, kind != 0, adr, wd, drop, lat);
            if (kind != 1) begin
                exp_last = ref_line(adr);
                chk($sformatf("rnd%0d_lat", t), 64'(lat), 64'(RD_LAT));
                chk($sformatf("rnd%0d_we_low", t), 64'(we_low), 64'd0);
            end else begin
                ref_write(adr, wd);
                chk($sformatf("rnd%0d_lat", t), 64'(lat), 64'(WR_LAT));
                chk($sformatf("rnd%0d_we_low", t), 64'(we_low), 64'(2 * (N - 1)));
            end
            chk($sformatf("rnd%0d_rdata", t), rsp_rdata, exp_last);
        end

        // final sweep: every line touched by the random phase matches the model
        for (int a = 128; a < 192; a += 4) begin
            line = {sram_mem[a+3], sram_mem[a+2], sram_mem[a+1], sram_mem[a]};
            chk($sformatf("mem_line_%0h", a), line, ref_line(32'(a) << 1));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
